spraid_wb_arbiter: RTL and testbench

Two-master Wishbone arbiter placed in front of the SPI RAID Wishbone slave (wb_spraid). It shares the single RAID array between a CPU port (m0) and a DMA/rebuild port (m1).
- Arbitration is round-robin.
- A grant is held for a whole bus cycle; WB lock extends it.
- A watchdog timeout aborts a transaction the slave never acks and returns an error to the master.
- A saturating timeout counter is exported for status.

---
 rtl/spraid_pkg.sv | 30 +++
 rtl/spraid_arb_watchdog.sv | 57 +++++
 rtl/spraid_wb_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_spraid_wb_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spraid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spraid_pkg
// Description : Shared definitions for the SPI RAID Wishbone arbiter:
//               FSM state encodings, master count, SPRAID address map and a
//               helper that turns the FSM state into a one-hot grant vector.
// Revision    : 1.0 - initial release
// ============================================================================
package spraid_pkg;

    localparam int NUM_MASTERS = 2;

    // Arbiter FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;
    localparam logic [1:0] ST_ABORT  = 2'd3;

    // SPRAID slave address map
    localparam logic [31:0] SPRAID_BASE_ADDR      = 32'h3000_0000;
    localparam logic [31:0] SPRAID_RAID_TYPE_ADDR = SPRAID_BASE_ADDR + 32'h0000_0400;
    localparam logic [31:0] SPRAID_STATUS_ADDR    = SPRAID_BASE_ADDR + 32'h0000_0401;

    // One-hot grant derived from the FSM state; ABORT and IDLE grant nobody.
    function automatic logic [NUM_MASTERS-1:0] state_to_grant(input logic [1:0] st);
        return {st == ST_GRANT1, st == ST_GRANT0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spraid_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : spraid_arb_watchdog
// Description : Bus-cycle watchdog for the SPRAID arbiter plus a saturating
//               count of aborted transactions.
// Ports       : clk, rst_n       - clock, asynchronous active-low reset
//               i_clr            - clear the cycle counter (takes priority)
//               i_en             - count this cycle (granted, s_cyc_o high)
//               i_abort          - bump the saturating abort counter
//               o_expire         - limit reached this cycle with no clear
//               o_abort_cnt      - saturating abort count
// Revision    : 1.0 - initial release
// ============================================================================
module spraid_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TOCNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic               i_abort,
    output logic               o_expire,
    output logic [TOCNT_W-1:0] o_abort_cnt
);

    localparam int                 c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [TOCNT_W-1:0] r_abort_cnt;

    // A clear in the same cycle as the limit suppresses the expiry, so a
    // late ack always beats the watchdog.
    assign o_expire    = i_en && !i_clr && (r_cnt == c_LIMIT);
    assign o_abort_cnt = r_abort_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_expire) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_abort_cnt <= '0;
        end else if (i_abort && (r_abort_cnt != '1)) begin
            r_abort_cnt <= r_abort_cnt + TOCNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/spraid_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spraid_wb_arbiter
// Description : Two-master round-robin Wishbone arbiter in front of the SPI
//               RAID slave. m0 = CPU, m1 = DMA/rebuild. A grant lasts a whole
//               bus cycle (extended by lock); a watchdog aborts cycles the
//               slave never answers and reports err to the owning master.
// Ports       : wb_clk_i/wb_rst_ni      - clock, async active-low reset
//               m{0,1}_*                - master-side Wishbone ports
//               s_*                     - slave-side Wishbone port
//               grant_o                 - one-hot grant (00 when idle/abort)
//               timeout_cnt_o           - saturating count of aborts
// Revision    : 1.0 - initial release
// ============================================================================
module spraid_wb_arbiter
    import spraid_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TOCNT_W        = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   m0_cyc_i,
    input  logic                   m0_stb_i,
    input  logic                   m0_we_i,
    input  logic                   m0_lock_i,
    input  logic                   m0_sel_i,
    input  logic [ADDR_W-1:0]      m0_adr_i,
    input  logic [DATA_W-1:0]      m0_dat_i,
    output logic [DATA_W-1:0]      m0_dat_o,
    output logic                   m0_ack_o,
    output logic                   m0_stall_o,
    output logic                   m0_err_o,
    input  logic                   m1_cyc_i,
    input  logic                   m1_stb_i,
    input  logic                   m1_we_i,
    input  logic                   m1_lock_i,
    input  logic                   m1_sel_i,
    input  logic [ADDR_W-1:0]      m1_adr_i,
    input  logic [DATA_W-1:0]      m1_dat_i,
    output logic [DATA_W-1:0]      m1_dat_o,
    output logic                   m1_ack_o,
    output logic                   m1_stall_o,
    output logic                   m1_err_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic                   s_lock_o,
    output logic                   s_sel_o,
    output logic [ADDR_W-1:0]      s_adr_o,
    output logic [DATA_W-1:0]      s_dat_o,
    input  logic [DATA_W-1:0]      s_dat_i,
    input  logic                   s_ack_i,
    input  logic                   s_stall_i,
    input  logic                   s_err_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [TOCNT_W-1:0]     timeout_cnt_o
);

    logic [1:0] r_state;
    logic       r_last_grant;   // in ABORT this also names the aborted master

    logic              w_granted;
    logic              w_cur;      // index of the master currently granted
    logic              w_cyc;
    logic              w_stb;
    logic              w_we;
    logic              w_lock;
    logic              w_sel;
    logic [ADDR_W-1:0] w_adr;
    logic [DATA_W-1:0] w_dat;
    logic              w_expire;

    assign w_granted = (r_state == ST_GRANT0) || (r_state == ST_GRANT1);
    assign w_cur     = (r_state == ST_GRANT1);

    // Select the owning master's request signals once, then route.
    assign w_cyc  = w_cur ? m1_cyc_i  : m0_cyc_i;
    assign w_stb  = w_cur ? m1_stb_i  : m0_stb_i;
    assign w_we   = w_cur ? m1_we_i   : m0_we_i;
    assign w_lock = w_cur ? m1_lock_i : m0_lock_i;
    assign w_sel  = w_cur ? m1_sel_i  : m0_sel_i;
    assign w_adr  = w_cur ? m1_adr_i  : m0_adr_i;
    assign w_dat  = w_cur ? m1_dat_i  : m0_dat_i;

    assign grant_o = state_to_grant(r_state);

    always_comb begin
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_lock_o   = 1'b0;
        s_sel_o    = 1'b0;
        s_adr_o    = '0;
        s_dat_o    = '0;
        m0_dat_o   = '0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_stall_o = 1'b1;
        m1_dat_o   = '0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_stall_o = 1'b1;
        if (w_granted) begin
            s_cyc_o  = w_cyc;
            s_stb_o  = w_cyc & w_stb;
            s_we_o   = w_we;
            s_lock_o = w_lock;
            s_sel_o  = w_sel;
            s_adr_o  = w_adr;
            s_dat_o  = w_dat;
            if (w_cur) begin
                m1_dat_o   = s_dat_i;
                m1_ack_o   = s_ack_i;
                m1_err_o   = s_err_i;
                m1_stall_o = s_stall_i;
            end else begin
                m0_dat_o   = s_dat_i;
                m0_ack_o   = s_ack_i;
                m0_err_o   = s_err_i;
                m0_stall_o = s_stall_i;
            end
        end else if (r_state == ST_ABORT) begin
            if (r_last_grant) begin
                m1_err_o = 1'b1;
            end else begin
                m0_err_o = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Round-robin: on contention the master that did not
                    // own the bus last time wins.
                    if (m0_cyc_i && (!m1_cyc_i || r_last_grant)) begin
                        r_state <= ST_GRANT0;
                    end else if (m1_cyc_i) begin
                        r_state <= ST_GRANT1;
                    end
                end
                ST_GRANT0, ST_GRANT1: begin
                    if (w_expire) begin
                        r_state      <= ST_ABORT;
                        r_last_grant <= w_cur;
                    end else if (!w_cyc && !w_lock) begin
                        r_state      <= ST_IDLE;
                        r_last_grant <= w_cur;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Counter is held clear outside a grant, so entry to GRANTn starts at 0.
    spraid_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TOCNT_W        (TOCNT_W)
    ) u_watchdog (
        .clk         (wb_clk_i),
        .rst_n       (wb_rst_ni),
        .i_clr       (!w_granted || s_ack_i || s_err_i),
        .i_en        (w_granted && s_cyc_o),
        .i_abort     (r_state == ST_ABORT),
        .o_expire    (w_expire),
        .o_abort_cnt (timeout_cnt_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_spraid_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spraid_wb_arbiter
// Description : Directed self-checking bench for spraid_wb_arbiter. Expected
//               master responses are queued as stimulus is issued; a monitor
//               pops and compares whenever a master sees ack or err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spraid_wb_arbiter;
    import spraid_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          m0_cyc, m0_stb, m0_we, m0_lock, m0_sel;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_dat;
    logic [DW-1:0] m0_dat_o;
    logic          m0_ack_o, m0_stall_o, m0_err_o;
    logic          m1_cyc, m1_stb, m1_we, m1_lock, m1_sel;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_dat;
    logic [DW-1:0] m1_dat_o;
    logic          m1_ack_o, m1_stall_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o, s_lock_o, s_sel_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i, s_stall_i, s_err_i;
    logic [1:0]    grant_o;
    logic [CW-1:0] timeout_cnt_o;

    spraid_wb_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .TOCNT_W(CW)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_lock_i(m0_lock),
        .m0_sel_i(m0_sel), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_stall_o(m0_stall_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_lock_i(m1_lock),
        .m1_sel_i(m1_sel), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_stall_o(m1_stall_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_lock_o(s_lock_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_stall_i(s_stall_i), .s_err_i(s_err_i),
        .grant_o(grant_o), .timeout_cnt_o(timeout_cnt_o)
    );

    typedef struct packed {
        logic          m;
        logic          err;
        logic [DW-1:0] dat;
    } resp_t;

    resp_t sb_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input logic m, input logic err, input logic [DW-1:0] dat);
        resp_t r;
        r.m   = m;
        r.err = err;
        r.dat = dat;
        sb_q.push_back(r);
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_lock = 0; m0_sel = 0; m0_adr = '0; m0_dat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_lock = 0; m1_sel = 0; m1_adr = '0; m1_dat = '0;
        s_dat_i = '0; s_ack_i = 0; s_stall_i = 0; s_err_i = 0;
        rst_n = 0;
        pos();
        pos();
        rst_n = 1;
    endtask

    // Response monitor
    logic          mon_a, mon_e;
    logic [DW-1:0] mon_d;
    resp_t         mon_r;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int m = 0; m < 2; m++) begin
                mon_a = (m == 1) ? m1_ack_o : m0_ack_o;
                mon_e = (m == 1) ? m1_err_o : m0_err_o;
                mon_d = (m == 1) ? m1_dat_o : m0_dat_o;
                if (mon_a || mon_e) begin
                    n_tests++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL resp_unexpected: m%0d ack=%0b err=%0b dat=0x%0h, required no response",
                                 m, mon_a, mon_e, mon_d);
                    end else begin
                        mon_r = sb_q.pop_front();
                        if (mon_r.m != 1'(m) || mon_r.err != mon_e || mon_a == mon_e ||
                            (!mon_e && mon_d != mon_r.dat)) begin
                            n_fail++;
                            $display("FAIL resp_m%0d: got ack=%0b err=%0b dat=0x%0h, required m%0d err=%0b dat=0x%0h",
                                     m, mon_a, mon_e, mon_d, mon_r.m, mon_r.err, mon_r.dat);
                        end
                    end
                end
            end
        end
    end

    initial begin
        // ---- 1: reset values
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_lock = 0; m0_sel = 0; m0_adr = '0; m0_dat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_lock = 0; m1_sel = 0; m1_adr = '0; m1_dat = '0;
        s_dat_i = '0; s_ack_i = 0; s_stall_i = 0; s_err_i = 0;
        rst_n = 0;
        neg(); neg();
        chk("rst_m0_stall", 32'(m0_stall_o), 1);
        chk("rst_m1_stall", 32'(m1_stall_o), 1);
        chk("rst_s_cyc", 32'(s_cyc_o), 0);
        chk("rst_grant", 32'(grant_o), 0);
        chk("rst_tocnt", 32'(timeout_cnt_o), 0);
        chk("rst_m0_ack", 32'(m0_ack_o), 0);
        chk("rst_m1_dat", m1_dat_o, 0);
        pos();
        rst_n = 1;

        // ---- 2: lone m1 read of RAID type
        pos();
        m1_cyc = 1; m1_stb = 1; m1_sel = 1; m1_adr = SPRAID_RAID_TYPE_ADDR;
        neg();
        chk("t2_latency_grant", 32'(grant_o), 0);
        chk("t2_latency_s_cyc", 32'(s_cyc_o), 0);
        pos();
        s_ack_i = 1; s_dat_i = 32'h1;
        expect_resp(1'b1, 1'b0, 32'h1);
        neg();
        chk("t2_grant", 32'(grant_o), 32'b10);
        chk("t2_s_adr", s_adr_o, SPRAID_RAID_TYPE_ADDR);
        chk("t2_s_stb", 32'(s_stb_o), 1);
        chk("t2_m0_stall", 32'(m0_stall_o), 1);
        chk("t2_m1_dat", m1_dat_o, 32'h1);
        pos();
        m1_cyc = 0; m1_stb = 0; s_ack_i = 0; s_dat_i = '0;
        pos();
        neg();
        chk("t2_release_grant", 32'(grant_o), 0);

        // ---- 3: both request from reset, round-robin
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = SPRAID_BASE_ADDR;
        m1_cyc = 1; m1_stb = 1; m1_adr = SPRAID_STATUS_ADDR;
        neg();
        chk("t3_idle_grant", 32'(grant_o), 0);
        pos();
        s_ack_i = 1; s_dat_i = 32'hA0;
        expect_resp(1'b0, 1'b0, 32'hA0);
        neg();
        chk("t3_m0_first", 32'(grant_o), 32'b01);
        chk("t3_m1_stalled", 32'(m1_stall_o), 1);
        chk("t3_s_adr_m0", s_adr_o, SPRAID_BASE_ADDR);
        pos();
        s_ack_i = 0; m0_cyc = 0; m0_stb = 0;
        pos();
        m0_cyc = 1; m0_stb = 1;
        neg();
        chk("t3_gap_idle", 32'(grant_o), 0);
        pos();
        s_ack_i = 1; s_dat_i = 32'hB1;
        expect_resp(1'b1, 1'b0, 32'hB1);
        neg();
        chk("t3_m1_second", 32'(grant_o), 32'b10);
        chk("t3_m0_stalled", 32'(m0_stall_o), 1);
        chk("t3_s_adr_m1", s_adr_o, SPRAID_STATUS_ADDR);
        pos();
        s_ack_i = 0; m1_cyc = 0; m1_stb = 0;
        pos();
        neg();
        chk("t3_gap2_idle", 32'(grant_o), 0);
        pos();
        s_ack_i = 1; s_dat_i = 32'hC0;
        expect_resp(1'b0, 1'b0, 32'hC0);
        neg();
        chk("t3_m0_again", 32'(grant_o), 32'b01);
        pos();
        s_ack_i = 0; m0_cyc = 0; m0_stb = 0;
        pos();

        // ---- 4: locked m0 holds grant across a cyc gap
        m0_cyc = 1; m0_stb = 1; m0_lock = 1; m0_we = 1; m0_dat = 32'hD0;
        pos();
        s_ack_i = 1; s_dat_i = '0;
        expect_resp(1'b0, 1'b0, 32'h0);
        neg();
        chk("t4_s_lock", 32'(s_lock_o), 1);
        chk("t4_s_we", 32'(s_we_o), 1);
        chk("t4_s_dat", s_dat_o, 32'hD0);
        pos();
        s_ack_i = 0; m0_cyc = 0; m0_stb = 0;
        m1_cyc = 1; m1_stb = 1;
        neg();
        chk("t4_hold_grant", 32'(grant_o), 32'b01);
        chk("t4_hold_s_cyc", 32'(s_cyc_o), 0);
        repeat (20) pos();
        neg();
        chk("t4_hold_long_grant", 32'(grant_o), 32'b01);
        chk("t4_hold_m1_stall", 32'(m1_stall_o), 1);
        pos();
        m0_cyc = 1; m0_stb = 1; s_ack_i = 1;
        expect_resp(1'b0, 1'b0, 32'h0);
        neg();
        chk("t4_second_s_cyc", 32'(s_cyc_o), 1);
        pos();
        s_ack_i = 0; m0_cyc = 0; m0_stb = 0; m0_lock = 0; m0_we = 0;
        neg();
        chk("t4_unlock_edge_grant", 32'(grant_o), 32'b01);
        pos();
        neg();
        chk("t4_unlock_idle", 32'(grant_o), 0);
        pos();
        neg();
        chk("t4_m1_after_unlock", 32'(grant_o), 32'b10);
        pos();
        m1_cyc = 0; m1_stb = 0;
        pos();

        // ---- 6: ack on the expiry cycle wins
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = SPRAID_BASE_ADDR;
        pos();
        repeat (TO - 1) pos();
        s_ack_i = 1; s_dat_i = 32'hE0;
        expect_resp(1'b0, 1'b0, 32'hE0);
        neg();
        chk("t6_expiry_s_cyc", 32'(s_cyc_o), 1);
        pos();
        s_ack_i = 0; m0_cyc = 0; m0_stb = 0;
        neg();
        chk("t6_no_abort", 32'(grant_o), 32'b01);
        pos();
        neg();
        chk("t6_tocnt", 32'(timeout_cnt_o), 0);

        // ---- 5: slave never acks, abort and saturation
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = SPRAID_BASE_ADDR;
        expect_resp(1'b0, 1'b1, 32'h0);
        pos();
        repeat (TO - 1) pos();
        neg();
        chk("t5_last_grant_cycle", 32'(grant_o), 32'b01);
        chk("t5_last_s_cyc", 32'(s_cyc_o), 1);
        chk("t5_no_err_yet", 32'(m0_err_o), 0);
        pos();
        neg();
        chk("t5_abort_err", 32'(m0_err_o), 1);
        chk("t5_abort_s_cyc", 32'(s_cyc_o), 0);
        chk("t5_abort_ack", 32'(m0_ack_o), 0);
        pos();
        m0_cyc = 0; m0_stb = 0;
        neg();
        chk("t5_tocnt_one", 32'(timeout_cnt_o), 1);
        chk("t5_err_one_cycle", 32'(m0_err_o), 0);
        for (int i = 0; i < 255; i++) begin
            m0_cyc = 1; m0_stb = 1;
            expect_resp(1'b0, 1'b1, 32'h0);
            repeat (TO + 1) pos();
            m0_cyc = 0; m0_stb = 0;
            pos();
        end
        neg();
        chk("t5_tocnt_saturated", 32'(timeout_cnt_o), 255);
        chk("sb_drained", 32'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
